// File: rtl/zx_vram_video_fetch.sv
// ZX Spectrum video fetch: turns pixel-timing coordinates into VRAM bitmap and
// attribute reads, and produces 24-bit RGB with ink/paper/bright/flash decoding
// plus border colour. The 256x192 screen is doubled to 512x384 and placed in a
// 640x480 raster. The VRAM port returns data one clock after the address is
// presented.
module zx_vram_video_fetch #(
    parameter int H_START = 64,
    parameter int V_START = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        de,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_start,
    input  logic [2:0]  border,
    output logic [12:0] vad,
    input  logic [7:0]  vdata,
    output logic [23:0] rgb,
    output logic        rgb_de
);

    // Window limits, widened to 11 bits so H_START+512 never wraps.
    localparam logic [10:0] WIN_X_LO = 11'(H_START);
    localparam logic [10:0] WIN_X_HI = 11'(H_START + 512);
    localparam logic [10:0] PF_X_LO  = 11'(H_START - 16);
    localparam logic [10:0] PF_X_HI  = 11'(H_START + 496);
    localparam logic [10:0] WIN_Y_LO = 11'(V_START);
    localparam logic [10:0] WIN_Y_HI = 11'(V_START + 384);

    // Offsets used to derive cell/phase, ZX line and the shift cadence.
    localparam logic [9:0]  PF_OFS   = 10'(H_START - 16);
    localparam logic [9:0]  X_OFS    = 10'(H_START);
    localparam logic [9:0]  Y_OFS    = 10'(V_START);

    localparam logic [7:0]  LVL_OFF    = 8'h00;
    localparam logic [7:0]  LVL_NORMAL = 8'hD7;
    localparam logic [7:0]  LVL_BRIGHT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BMP_ADDR  = 3'd1,
        ST_ATTR_ADDR = 3'd2,
        ST_WAIT      = 3'd3,
        ST_LOAD      = 3'd4
    } fetch_state_e;

    // One colour component: off, normal or bright intensity.
    function automatic logic [7:0] comp_level(input logic on, input logic bright);
        logic [7:0] lvl;
        if (!on) begin
            lvl = LVL_OFF;
        end else if (bright) begin
            lvl = LVL_BRIGHT;
        end else begin
            lvl = LVL_NORMAL;
        end
        return lvl;
    endfunction

    // ZX colour index is {G,R,B}; output packing is {R,G,B}.
    function automatic logic [23:0] zx_colour(input logic [2:0] c, input logic bright);
        return {comp_level(c[1], bright), comp_level(c[2], bright), comp_level(c[0], bright)};
    endfunction

    // Registers
    fetch_state_e state_q;
    logic [12:0]  vad_q;
    logic [7:0]   fetch_bmp_q;
    logic [7:0]   fetch_attr_q;
    logic [7:0]   shift_q;
    logic [7:0]   attr_q;
    logic [4:0]   flash_q;
    logic [23:0]  rgb_q;
    logic         rgb_de_q;

    // Combinational decode of the current coordinate
    logic [10:0]  x_ext_s;
    logic [10:0]  y_ext_s;
    logic         row_in_win_s;
    logic         in_win_s;
    logic         pf_s;
    logic [4:0]   col_s;
    logic [3:0]   phase_s;
    logic [7:0]   zy_s;
    logic         odd_px_s;
    logic [12:0]  bmp_addr_s;
    logic [12:0]  attr_addr_s;
    logic         load_s;
    logic         shift_tick_s;
    logic         flip_s;
    logic [2:0]   sel_colour_s;
    logic [23:0]  win_rgb_s;
    logic [23:0]  border_rgb_s;

    assign x_ext_s      = {1'b0, x};
    assign y_ext_s      = {1'b0, y};
    assign row_in_win_s = (y_ext_s >= WIN_Y_LO) && (y_ext_s < WIN_Y_HI);
    assign in_win_s     = de && row_in_win_s && (x_ext_s >= WIN_X_LO) && (x_ext_s < WIN_X_HI);
    assign pf_s         = de && row_in_win_s && (x_ext_s >= PF_X_LO) && (x_ext_s < PF_X_HI);

    // u = x - H_START + 16: column in bits [8:4], phase in bits [3:0].
    assign col_s    = 5'((x - PF_OFS) >> 4);
    assign phase_s  = 4'(x - PF_OFS);
    assign zy_s     = 8'((y - Y_OFS) >> 1);
    assign odd_px_s = 1'(x - X_OFS);

    // ZX bitmap layout interleaves thirds, character rows and pixel rows.
    assign bmp_addr_s  = {zy_s[7:6], zy_s[2:0], zy_s[5:3], col_s};
    assign attr_addr_s = {3'b110, zy_s[7:3], col_s};

    // The cell is handed to the display at the last phase of a complete pass.
    assign load_s       = pf_s && (state_q == ST_WAIT) && (phase_s == 4'd15);
    assign shift_tick_s = in_win_s && odd_px_s;

    // Pixel colour selection with flash swap, plus border colour.
    always_comb begin
        flip_s       = attr_q[7] & flash_q[4];
        sel_colour_s = 3'b000;
        if (shift_q[7] ^ flip_s) begin
            sel_colour_s = attr_q[2:0];
        end else begin
            sel_colour_s = attr_q[5:3];
        end
        win_rgb_s    = zx_colour(sel_colour_s, attr_q[6]);
        border_rgb_s = zx_colour(border, 1'b0);
    end

    // Fetch sequencer: one bitmap+attribute read pass per 16-clock cell.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            vad_q        <= 13'd0;
            fetch_bmp_q  <= 8'd0;
            fetch_attr_q <= 8'd0;
        end else if (!pf_s) begin
            state_q <= ST_IDLE;
            vad_q   <= 13'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (phase_s == 4'd0) begin
                        state_q <= ST_BMP_ADDR;
                        vad_q   <= bmp_addr_s;
                    end else begin
                        state_q <= ST_IDLE;
                        vad_q   <= 13'd0;
                    end
                end
                ST_BMP_ADDR: begin
                    if (phase_s == 4'd1) begin
                        state_q <= ST_ATTR_ADDR;
                        vad_q   <= attr_addr_s;
                    end else begin
                        state_q <= ST_IDLE;
                        vad_q   <= 13'd0;
                    end
                end
                ST_ATTR_ADDR: begin
                    // Bitmap read issued in BMP_ADDR is on vdata now.
                    state_q     <= ST_WAIT;
                    fetch_bmp_q <= vdata;
                end
                ST_WAIT: begin
                    // Attribute read issued in ATTR_ADDR lands one phase later.
                    if (phase_s == 4'd3) begin
                        fetch_attr_q <= vdata;
                    end
                    if (phase_s == 4'd15) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (phase_s == 4'd0) begin
                        state_q <= ST_BMP_ADDR;
                        vad_q   <= bmp_addr_s;
                    end else begin
                        state_q <= ST_IDLE;
                        vad_q   <= 13'd0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    vad_q   <= 13'd0;
                end
            endcase
        end
    end

    // Display latches: load a fetched cell, then shift one bit per two pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= 8'd0;
            attr_q  <= 8'd0;
        end else if (load_s) begin
            shift_q <= fetch_bmp_q;
            attr_q  <= fetch_attr_q;
        end else if (shift_tick_s) begin
            shift_q <= {shift_q[6:0], 1'b0};
        end
    end

    // Flash counter: bit 4 toggles every 16 frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            flash_q <= 5'd0;
        end else if (frame_start) begin
            flash_q <= flash_q + 5'd1;
        end
    end

    // Registered colour output aligned with delayed display enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q    <= 24'd0;
            rgb_de_q <= 1'b0;
        end else if (!de) begin
            rgb_q    <= 24'd0;
            rgb_de_q <= 1'b0;
        end else if (in_win_s) begin
            rgb_q    <= win_rgb_s;
            rgb_de_q <= 1'b1;
        end else begin
            rgb_q    <= border_rgb_s;
            rgb_de_q <= 1'b1;
        end
    end

    assign vad    = vad_q;
    assign rgb    = rgb_q;
    assign rgb_de = rgb_de_q;

endmodule

// File: tb/tb_zx_vram_video_fetch.sv
// Bench for zx_vram_video_fetch: random VRAM contents and scan lines, checked
// pixel by pixel against a screen-level model of the ZX display.
module tb_zx_vram_video_fetch;

    localparam int H_START = 64;
    localparam int V_START = 48;

    logic        clk = 1'b0;
    logic        reset;
    logic        de;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        frame_start;
    logic [2:0]  border;
    logic [12:0] vad;
    logic [7:0]  vdata;
    logic [23:0] rgb;
    logic        rgb_de;

    logic [7:0]  mem [0:8191];

    int n_cmp;
    int n_err;
    int fcount;     // frame_start pulses since last reset
    int good_cell;  // display cells below this index were never fully fetched

    zx_vram_video_fetch #(.H_START(H_START), .V_START(V_START)) dut (
        .clk(clk), .reset(reset), .de(de), .x(x), .y(y),
        .frame_start(frame_start), .border(border), .vad(vad),
        .vdata(vdata), .rgb(rgb), .rgb_de(rgb_de)
    );

    always #5 clk = ~clk;

    // VRAM video port: synchronous read, one cycle latency.
    always @(posedge clk) vdata <= mem[vad];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s x=%0d y=%0d: got %h expected %h", tag, x, y, obs, exp);
        end
    endtask

    function automatic logic [7:0] level(input bit on, input bit br);
        if (!on) return 8'h00;
        return br ? 8'hFF : 8'hD7;
    endfunction

    function automatic logic [23:0] colour(input logic [2:0] c, input bit br);
        // c = {G,R,B}; output {R,G,B}
        return {level(c[1], br), level(c[2], br), level(c[0], br)};
    endfunction

    function automatic int bmp_addr(input int zy, input int col);
        return (zy / 64) * 2048 + (zy % 8) * 256 + ((zy / 8) % 8) * 32 + col;
    endfunction

    function automatic int attr_addr(input int zy, input int col);
        return 6144 + (zy / 8) * 32 + col;
    endfunction

    function automatic logic [23:0] ref_rgb(input int xi, input int yi, input logic [2:0] brd,
                                            input int fc, input int gc);
        int zx, zy, col;
        logic [7:0] b, a;
        bit pix, flip;
        logic [2:0] c;
        if (xi < H_START || xi >= H_START + 512 || yi < V_START || yi >= V_START + 384)
            return colour(brd, 1'b0);
        zx  = (xi - H_START) / 2;
        zy  = (yi - V_START) / 2;
        col = zx / 8;
        if (col < gc) return 24'h000000;
        b    = mem[bmp_addr(zy, col)];
        a    = mem[attr_addr(zy, col)];
        pix  = b[7 - (zx % 8)];
        flip = a[7] && ((fc % 32) >= 16);
        c    = (pix ^ flip) ? a[2:0] : a[5:3];
        return colour(c, a[6]);
    endfunction

    // One clock: apply inputs, predict, check after the edge, advance model.
    task automatic tick(input bit d, input int xi, input int yi, input bit fs, input bit rs);
        logic [23:0] e_rgb;
        logic        e_de;
        logic [12:0] e_vad;
        bit          vchk;
        bit          pf;
        int          u;
        reset = rs; de = d; x = 10'(xi); y = 10'(yi); frame_start = fs;
        u  = xi - H_START + 16;
        pf = d && yi >= V_START && yi < V_START + 384 &&
             xi >= H_START - 16 && xi < H_START + 496;
        e_vad = 13'd0;
        vchk  = 1'b1;
        if (rs) begin
            e_rgb = 24'h0;
            e_de  = 1'b0;
        end else begin
            e_de  = d;
            e_rgb = d ? ref_rgb(xi, yi, border, fcount, good_cell) : 24'h0;
            if (pf) begin
                if (u % 16 == 0)      e_vad = 13'(bmp_addr((yi - V_START) / 2, u / 16));
                else if (u % 16 == 1) e_vad = 13'(attr_addr((yi - V_START) / 2, u / 16));
                else                  vchk  = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("rgb", 32'(rgb), 32'(e_rgb));
        chk("rgb_de", 32'(rgb_de), 32'(e_de));
        if (vchk) chk("vad", 32'(vad), 32'(e_vad));
        if (rs) begin
            fcount    = 0;
            good_cell = 99;
        end else begin
            if (fs) fcount++;
            if (pf && (u % 16 == 0) && (good_cell == 99 || u == 0)) good_cell = u / 16;
        end
    endtask

    task automatic scan_line(input int yi, input int rst_at, input bit fs_mid);
        for (int xi = 0; xi < 640; xi++)
            tick(1'b1, xi, yi, fs_mid && xi == 300,
                 rst_at >= 0 && xi >= rst_at && xi < rst_at + 3);
        for (int k = 0; k < 8; k++) tick(1'b0, 0, yi, 1'b0, 1'b0);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            tick(1'b0, 0, 0, 1'b1, 1'b0);
            tick(1'b0, 0, 0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; fcount = 0; good_cell = 99;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        // Y=65 cells 3..5: plain, bright and flashing red-on-blue.
        mem['h0903] = 8'h80; mem['h1903] = 8'h0A;
        mem['h0904] = 8'h80; mem['h1904] = 8'h4A;
        mem['h0905] = 8'h80; mem['h1905] = 8'h8A;
        border = 3'b100;
        reset = 1'b1; de = 1'b0; x = 10'd0; y = 10'd0; frame_start = 1'b0;

        // Power-on reset
        for (int k = 0; k < 3; k++) tick(1'b0, 0, 0, 1'b0, 1'b1);
        tick(1'b0, 0, 0, 1'b0, 1'b0);

        scan_line(V_START + 130, -1, 1'b0);   // Y=65, flash phase 0
        scan_line(10, -1, 1'b0);              // all-border line, green
        for (int k = 0; k < 5; k++) begin
            border = 3'($urandom);
            scan_line($urandom_range(479, 0), -1, 1'b0);
        end
        scan_line(V_START + 131, -1, 1'b0);

        frames(16);                           // flash phase 1
        scan_line(V_START + 130, -1, 1'b0);
        border = 3'($urandom);
        scan_line($urandom_range(V_START + 383, V_START), -1, 1'b1); // pulse mid-line -> 17
        frames(15);                           // 32 -> unswapped again
        scan_line(V_START + 130, -1, 1'b0);

        frames(16);                           // phase 1, then reset mid-line
        scan_line(V_START + 130, 200, 1'b0);
        scan_line(V_START + 131, -1, 1'b0);
        scan_line(V_START + 130, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
